booth_radix4_mult: RTL
======================

# booth_radix4_mult

Parametrised, sequential, signed radix-4 Booth multiplier with a start/done handshake. It is the successor to the fixed 8-bit switch-loaded Booth datapath and controller pair. Operands arrive in parallel on one cycle, and each radix-4 recode, add and shift step completes in a single cycle. The block sits between an operand source and any consumer of a 2×WIDTH-bit two's-complement product.

## Interface
Parameters:
- WIDTH, 8: operand width in bits. Must be even and ≥ 4.

Ports (one clock; reset is synchronous and active-high):
- clock  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high. Returns the block to IDLE and clears all outputs.
- start  input  1  request. Sampled only in IDLE.
- mcand  input  WIDTH  multiplicand, two's complement. Captured on the accepting edge.
- mplier  input  WIDTH  multiplier, two's complement. Captured on the accepting edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; product is valid in this cycle.
- product  output  2*WIDTH  signed product. Held from done until the next accepted start.

## Operation
- Internal registers:
  - M: WIDTH bits.
  - A: WIDTH+2 bits, signed; headroom for ±2M, including 2×(−2^(WIDTH−1)).
  - Q: WIDTH bits.
  - q_m1: 1 bit.
  - cnt: clog2(WIDTH/2+1) bits.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1: M←mcand, A←0, Q←mplier, q_m1←0, cnt←WIDTH/2, go to RUN.
  - Otherwise stay in IDLE.
- RUN, one iteration per cycle:
  - Recode {Q[1],Q[0],q_m1}:
    - 000 or 111: +0
    - 001 or 010: +M
    - 011: +2M
    - 100: −2M
    - 101 or 110: −M
  - M is sign-extended to WIDTH+2 bits before the add.
  - A←A+recode, then arithmetic-shift {A,Q,q_m1} right by 2. q_m1 takes the old Q[1].
  - cnt←cnt−1. When cnt reaches 0, go to DONE.
- DONE:
  - product←{A[WIDTH−1:0],Q}; drive done=1 for one cycle, then go to IDLE.
  - A[WIDTH+1:WIDTH] are sign copies and are discarded.
- start while busy=1 (RUN or DONE) is ignored. Operands are not re-captured.
- start in the IDLE cycle immediately following DONE is accepted normally.
- Result is exact for all operand pairs; no overflow is possible.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, product=0.
  - A=0, Q=0, M=0, q_m1=0, cnt=0.
- Reset asserted mid-RUN or in DONE: takes effect on the next edge and the in-flight result is discarded. No done pulse occurs for the aborted operation.
- Latency, start accepted in cycle 0:
  - RUN occupies cycles 1…WIDTH/2.
  - done=1 in cycle WIDTH/2+1 (cycle 5 for WIDTH=8).
- busy rises in cycle 1 and falls in cycle WIDTH/2+2.
- Throughput: one multiply per WIDTH/2+2 cycles at most.
- product changes only on the edge entering DONE, or on reset.

## Configuration
- Macro BOOTH_EARLY_TERM_EN:
  - Defined:
    - Termination check: at the start of each RUN cycle, test whether Q[2*cnt−1:0] and q_m1 are all 0 or all 1.
    - If true, all remaining recodes are +0. Instead of an iteration, shift {A,Q} arithmetically right by 2*cnt in that cycle, force cnt←0, and go to DONE.
    - Latency becomes data-dependent, with a minimum of done in cycle 2.
    - Product value is identical to the non-terminating case.
  - Undefined: no check and no variable shifter. Latency is always WIDTH/2+1.

## Test plan
WIDTH=8 unless stated:
- Basic: mcand=7, mplier=3, start in cycle 0 → done=1 only in cycle 5, product=16'h0015, busy=1 in cycles 1–5.
- Extremes:
  - −128 × −128 → 16'h4000.
  - −128 × 127 → 16'hC080.
  - 127 × −1 → 16'hFF81.
  - Sweep all 65536 pairs against a signed reference model.
- Handshake: start held high through RUN with new operands 5×5 → the first result, 7×3=16'h0015, is unaffected. Releasing start in DONE and re-asserting it in the next IDLE → product 16'h0019 after 5 more cycles.
- Reset mid-operation: reset in cycle 3 of 100×100 → next cycle busy=0, done=0, product=0. No done pulse follows. A subsequent 2×−3 → 16'hFFFA.
- Early termination with macro defined:
  - 25×0 → done in cycle 2, product 0.
  - 25×−1 → done in cycle 3, product 16'hFFE7.
  - Macro undefined: both cases give done in cycle 5 with identical products.
- Width: WIDTH=16, −32768 × −32768 → 32'h40000000 with done in cycle 9.

Source files
------------

// File: rtl/booth_radix4_mult.sv
// Signed radix-4 Booth multiplier, one recode/add/shift step per cycle, start/done handshake.
// Latency: done in cycle WIDTH/2+1 after the accepting edge (data-dependent, min 2, with BOOTH_EARLY_TERM_EN).
// Backpressure: none; start is sampled only in IDLE and ignored while busy is high.
module booth_radix4_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int             CW   = $clog2(WIDTH/2 + 1);
    localparam logic [CW-1:0]  HALF = CW'(WIDTH/2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic [WIDTH-1:0]         r_m;
    logic signed [WIDTH+1:0]  r_a;
    logic [WIDTH-1:0]         r_q;
    logic                     r_qm1;
    logic [CW-1:0]            r_cnt;
    logic [2*WIDTH-1:0]       r_product;

    logic signed [WIDTH+1:0]  w_m_ext;
    logic signed [WIDTH+1:0]  w_addend;
    logic signed [WIDTH+1:0]  w_sum;
    logic signed [WIDTH+1:0]  w_a_step;
    logic [WIDTH-1:0]         w_q_step;
    logic                     w_last;
    logic                     w_early;

    // A carries two guard bits so that +/-2M, including 2*(-2^(WIDTH-1)), never overflows.
    assign w_m_ext  = {{2{r_m[WIDTH-1]}}, r_m};
    assign w_sum    = r_a + w_addend;
    assign w_a_step = {{2{w_sum[WIDTH+1]}}, w_sum[WIDTH+1:2]};
    assign w_q_step = {w_sum[1:0], r_q[WIDTH-1:2]};
    assign w_last   = (r_cnt == CW'(1));

    // Radix-4 Booth recode of {Q[1],Q[0],q_m1} into the partial-product addend.
    always_comb begin
        w_addend = '0;
        case ({r_q[1:0], r_qm1})
            3'b001, 3'b010: w_addend = w_m_ext;
            3'b011:         w_addend = w_m_ext <<< 1;
            3'b100:         w_addend = -(w_m_ext <<< 1);
            3'b101, 3'b110: w_addend = -w_m_ext;
            default:        w_addend = '0;
        endcase
    end

`ifdef BOOTH_EARLY_TERM_EN
    logic                     w_all0;
    logic                     w_all1;
    logic [CW:0]              w_shamt;
    logic signed [2*WIDTH+1:0] w_aq_sh;

    // Remaining multiplier bits below Q[2*cnt] are the only ones still to be recoded.
    assign w_shamt = {r_cnt, 1'b0};

    // If those bits and q_m1 are uniform, every remaining recode is +0.
    always_comb begin
        w_all0 = ~r_qm1;
        w_all1 = r_qm1;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < int'(w_shamt)) begin
                w_all0 = w_all0 & ~r_q[i];
                w_all1 = w_all1 & r_q[i];
            end
        end
    end

    assign w_early = w_all0 | w_all1;
    assign w_aq_sh = $signed({r_a, r_q}) >>> w_shamt;
`else
    assign w_early = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_early || w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, iteration datapath, and product load on the edge into DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_m       <= '0;
            r_a       <= '0;
            r_q       <= '0;
            r_qm1     <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m   <= mcand;
                        r_a   <= '0;
                        r_q   <= mplier;
                        r_qm1 <= 1'b0;
                        r_cnt <= HALF;
                    end
                end
                S_RUN: begin
`ifdef BOOTH_EARLY_TERM_EN
                    if (w_early) begin
                        r_a       <= w_aq_sh[2*WIDTH+1:WIDTH];
                        r_q       <= w_aq_sh[WIDTH-1:0];
                        r_cnt     <= '0;
                        r_product <= w_aq_sh[2*WIDTH-1:0];
                    end else
`endif
                    begin
                        r_a   <= w_a_step;
                        r_q   <= w_q_step;
                        r_qm1 <= r_q[1];
                        r_cnt <= r_cnt - CW'(1);
                        if (w_last) begin
                            r_product <= {w_a_step[WIDTH-1:0], w_q_step};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign product = r_product;

endmodule
